sipo_rx: RTL and testbench
==========================

// Module: sipo_rx
//
// PURPOSE
// - Serial-in parallel-out receiver: far end of the 4-bit LSB-first parallel-in serial-out transmitter link.
// - Samples one bit per clock while sel=1 and assembles WIDTH-bit words LSB first.
// - Presents each completed word on a valid/ready holding register; flags overrun when the consumer stalls.
// - The transmitter's serial output is registered, so the link drives this block's sel from the transmitter's sel delayed one clock.
//
// PARAMETERS
// - WIDTH   4   word length in bits (>=2); CNT_W = $clog2(WIDTH)
//
// PORTS
// - clk        in   1      rising-edge clock, sole clock domain
// - rst        in   1      synchronous, active-high reset
// - sel        in   1      1 = inbit valid this cycle, shift it in; 0 = hold
// - inbit      in   1      serial data, LSB of word first
// - clr        in   1      sync abort: drop partial word, clear overrun
// - outdata    out  WIDTH  completed word, stable while out_valid=1
// - out_valid  out  1      outdata holds an unconsumed word
// - out_ready  in   1      consumer accepts outdata when out_valid & out_ready
// - busy       out  1      partial word in progress (bit_cnt != 0)
// - overrun    out  1      sticky: a completed word was dropped
//
// BEHAVIOUR
// - Reset (rst=1 at posedge): shreg=0, bit_cnt=0, state=IDLE, outdata=0, out_valid=0, overrun=0, busy=0.
// - rst has priority over clr; clr has priority over sel.
// - FSM: IDLE (bit_cnt=0) / SHIFT (0<bit_cnt<WIDTH).
//   IDLE & sel -> SHIFT; SHIFT & sel & bit_cnt==WIDTH-1 -> IDLE (word complete); sel=0 -> stay.
// - Shift rule on sel=1: shreg <= {inbit, shreg[WIDTH-1:1]}; bit_cnt <= bit_cnt+1, wraps to 0 at completion.
// - sel=0 mid-word: shreg and bit_cnt hold; gaps of any length allowed.
// - Completion cycle: new word W = {inbit, shreg[WIDTH-1:1]}.
//   - slot free (out_valid=0) or freed this cycle (out_valid & out_ready): outdata<=W, out_valid<=1.
//   - slot full and not freed: W discarded, outdata unchanged, overrun<=1.
// - Latency: last bit sampled at edge N -> out_valid=1 and outdata valid after edge N (visible cycle N+1).
// - Handshake: out_valid stays 1 until out_valid & out_ready at a posedge; outdata never changes while out_valid=1 except on a same-edge accept+reload.
// - Accept without completion: out_valid<=0, outdata holds last value.
// - clr: shreg=0, bit_cnt=0, state=IDLE, overrun=0; outdata/out_valid untouched; clr+out_ready still accepts.
// - overrun cleared only by rst or clr.
// - busy = (state==SHIFT), registered with state.
//
// STRUCTURE
// - Shared package piso_sipo_pkg: state encodings (S_IDLE=1'b0, S_SHIFT=1'b1), default WIDTH=4 for transmitter and receiver.
// - Top holds FSM, bit counter, shift register.
// - One sub-module: sipo_out_hold (WIDTH-wide valid/ready holding register with load, accept, overrun outputs).
//
// TESTING
// - Reset: rst=1 with sel=1, inbit=1 for 3 clk -> all outputs 0; release -> still 0 until 4 bits shifted.
// - Basic word: sel=1 for 4 clk, inbit 1,0,1,1 (LSB first), out_ready=1 -> outdata=4'b1101, out_valid high exactly 1 cycle.
// - Gapped input: bits 0,1 / sel=0 for 5 clk / bits 1,0 -> outdata=4'b0110; busy=1 throughout the gap.
// - Back-to-back + stall: words 4'hA then 4'h5 streamed, out_ready=0 -> outdata=4'hA held, overrun=1; then out_ready=1 -> accept A, overrun stays 1.
// - Same-edge accept+reload: word 4'h3 pending, 4'hC completes on the cycle out_ready=1 -> outdata=4'hC, out_valid stays 1, overrun=0.
// - Abort: 2 bits shifted, clr=1 -> busy=0; next 4 bits 1,1,1,1 -> outdata=4'hF; rst mid-word -> no word emitted.

Source files
------------

// File: rtl/piso_sipo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : piso_sipo_pkg
// Description : Shared constants for the 4-bit PISO transmitter / SIPO
//               receiver link: FSM state encodings and default word width.
// Revision    : 1.0  initial release
// ============================================================================
package piso_sipo_pkg;

  // Default word length shared by the transmitter and the receiver
  localparam int c_DEFAULT_WIDTH = 4;

  // FSM state encodings (IDLE: no partial word, SHIFT: partial word held)
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

endpackage : piso_sipo_pkg
`default_nettype wire

// File: rtl/sipo_rx_if.sv
`default_nettype none
// ============================================================================
// Interface   : sipo_rx_if
// Description : Serial input and valid/ready parallel output bundle of the
//               SIPO receiver. The slave side is the receiver; the master
//               side is the serial source plus the word consumer.
// Revision    : 1.0  initial release
// ============================================================================
interface sipo_rx_if
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) ();

  logic             sel;
  logic             inbit;
  logic             clr;
  logic [WIDTH-1:0] outdata;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  modport slave (
    input  sel,
    input  inbit,
    input  clr,
    input  out_ready,
    output outdata,
    output out_valid,
    output busy,
    output overrun
  );

  modport master (
    output sel,
    output inbit,
    output clr,
    output out_ready,
    input  outdata,
    input  out_valid,
    input  busy,
    input  overrun
  );

endinterface : sipo_rx_if
`default_nettype wire

// File: rtl/sipo_out_hold.sv
`default_nettype none
// ============================================================================
// Module      : sipo_out_hold
// Description : Single-entry valid/ready holding register for completed
//               words. A load into a full, un-freed slot is dropped and
//               raises a sticky overrun flag.
// Revision    : 1.0  initial release
// ============================================================================
module sipo_out_hold
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  wire             clk,
  input  wire             rst,
  input  wire             i_load,
  input  wire [WIDTH-1:0] i_word,
  input  wire             i_ready,
  input  wire             i_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_fire;

  // The slot counts as free when empty or when it is being emptied this edge
  assign w_fire = r_valid & i_ready;

  // Slot contents, handshake flag and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load && (!r_valid || w_fire)) begin
        r_data  <= i_word;
        r_valid <= 1'b1;
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end

      if (i_clr) begin
        r_overrun <= 1'b0;
      end else if (i_load && r_valid && !w_fire) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule : sipo_out_hold
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx
// Description : Serial-in parallel-out receiver. Shifts one bit per clock
//               while sel=1, LSB first, and hands each completed word to a
//               valid/ready holding register.
// Revision    : 1.0  initial release
// ============================================================================
module sipo_rx
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  wire      clk,
  input  wire      rst,
  sipo_rx_if.slave bus
);

  localparam int                 CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   c_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
  logic             w_busy;

  // Incoming bit enters at the MSB so the first bit ends up as the LSB
  assign w_word = {bus.inbit, r_shreg[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: abort wins over shifting, sel=0 holds
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = S_IDLE;
    end else if (bus.sel) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_SHIFT;
        S_SHIFT: w_state_nxt = (r_bit_cnt == c_LAST) ? S_IDLE : S_SHIFT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: busy mirrors the state, load fires on the last bit
  always_comb begin
    w_busy = (r_state == S_SHIFT);
    w_load = bus.sel & ~bus.clr & (r_state == S_SHIFT) & (r_bit_cnt == c_LAST);
  end

  // Shift register and bit counter; counter wraps to 0 on word completion
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (bus.sel) begin
      r_shreg   <= w_word;
      r_bit_cnt <= (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

  sipo_out_hold #(
    .WIDTH (WIDTH)
  ) u_out_hold (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_word    (w_word),
    .i_ready   (bus.out_ready),
    .i_clr     (bus.clr),
    .o_data    (bus.outdata),
    .o_valid   (bus.out_valid),
    .o_overrun (bus.overrun)
  );

  assign bus.busy = w_busy;

endmodule : sipo_rx
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_rx
// Description : Self-checking bench for sipo_rx with a word scoreboard and
//               a behavioural model of the receiver's visible state.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sipo_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sipo_rx_if #(.WIDTH(4)) bus ();

  sipo_rx #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the receiver
  logic [3:0] m_sh;
  int         m_cnt;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  logic [3:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sh = 4'h0; m_cnt = 0; m_data = 4'h0; m_valid = 1'b0; m_ovr = 1'b0;
    q.delete();
  endtask

  // One clock: check current outputs, drive inputs, advance model, clock
  task automatic step(input logic s, input logic b, input logic c, input logic r);
    logic       fire;
    logic [3:0] w;
    logic [3:0] exp_w;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("busy",      32'(bus.busy),      32'(m_cnt != 0));
    check("overrun",   32'(bus.overrun),   32'(m_ovr));
    if (m_valid) check("outdata_hold", 32'(bus.outdata), 32'(m_data));

    bus.sel = s; bus.inbit = b; bus.clr = c; bus.out_ready = r;
    fire = m_valid & r;
    if (fire) begin
      if (q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_w = q.pop_front();
        check("accepted_word", 32'(bus.outdata), 32'(exp_w));
      end
    end

    if (c) begin
      m_sh = 4'h0; m_cnt = 0; m_ovr = 1'b0;
      if (fire) m_valid = 1'b0;
    end else if (s) begin
      w = {b, m_sh[3:1]};
      m_sh = w;
      if (m_cnt == 3) begin
        m_cnt = 0;
        if (!m_valid || fire) begin
          m_data = w; m_valid = 1'b1; q.push_back(w);
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        m_cnt++;
        if (fire) m_valid = 1'b0;
      end
    end else if (fire) begin
      m_valid = 1'b0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] w, input logic r);
    for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, r);
  endtask

  // Reset held 3 clocks with sel=1, inbit=1 driven
  task automatic do_reset();
    rst = 1'b1;
    bus.sel = 1'b1; bus.inbit = 1'b1; bus.clr = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outdata",   32'(bus.outdata),   32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_overrun",   32'(bus.overrun),   32'd0);
    rst = 1'b0;
    bus.sel = 1'b0; bus.inbit = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.sel = 1'b0; bus.inbit = 1'b0; bus.clr = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    do_reset();

    // Three bits after reset: still nothing emitted
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_no_word", 32'(bus.out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Basic word 1,0,1,1 LSB first
    send_word(4'b1101, 1'b1);
    check("basic_word",  32'(bus.outdata),   32'hD);
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_valid_1cyc", 32'(bus.out_valid), 32'd0);

    // Gapped word: bits 0,1 / 5 idle clocks / bits 1,0
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("gap_busy", 32'(bus.busy), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("gap_word", 32'(bus.outdata), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with stalled consumer: A kept, 5 dropped
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    check("stall_word",    32'(bus.outdata), 32'hA);
    check("stall_overrun", 32'(bus.overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_overrun", 32'(bus.overrun), 32'd0);

    // Same-edge accept and reload: 3 pending, C completes with ready=1
    send_word(4'h3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("reload_word",    32'(bus.outdata),   32'hC);
    check("reload_valid",   32'(bus.out_valid), 32'd1);
    check("reload_overrun", 32'(bus.overrun),   32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort mid-word, then a clean word
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_busy", 32'(bus.busy), 32'd0);
    send_word(4'hF, 1'b1);
    check("abort_word", 32'(bus.outdata), 32'hF);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word: the remaining bits must not complete a word
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_no_word", 32'(bus.out_valid), 32'd0);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sipo_rx
`default_nettype wire
